// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : multicycle_ctrl
//  Purpose  : Multi-cycle sequencer for a single-issue RV32I core. Steps the
//             datapath through FETCH/DECODE/EXEC/MEM/WB, decodes the latched
//             instruction word, selects the immediate format and drives every
//             register, PC, memory and writeback enable. Handshakes with a
//             single shared instruction/data memory port.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    RETIRE_W        width of the retired-instruction counter (wraps)
//  Ports
//    clk             core clock, rising edge
//    rst             synchronous active-high reset
//    inst_i          instruction register contents (valid from DECODE on)
//    mem_ready_i     memory completes the current request this cycle
//    br_taken_i      branch comparison result, sampled in EXEC
//    mem_req_o       memory request, held until mem_ready_i
//    mem_we_o        store request (qualifies mem_req_o)
//    mem_addr_sel_o  0 = PC, 1 = ALU result
//    ir_we_o         latch fetched word into the instruction register
//    pc_we_o         PC update strobe
//    pc_src_o        0 = PC+4, 1 = PC+imm, 2 = (rs1+imm) & ~1
//    imm_sel_o       0 none, 1 I, 2 S, 3 B, 4 U, 5 J
//    alu_a_sel_o     0 = rs1, 1 = PC
//    alu_b_sel_o     0 = rs2, 1 = immediate
//    rf_we_o         register-file write strobe
//    wb_sel_o        0 = ALU, 1 = memory, 2 = PC+4, 3 = immediate
//    illegal_o       sticky unsupported-opcode flag
//    state_o         current sequencer state (debug)
//    retired_o       count of completed instructions
// ============================================================================
module multicycle_ctrl #(
    parameter int RETIRE_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         inst_i,
    input  logic                mem_ready_i,
    input  logic                br_taken_i,
    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic                mem_addr_sel_o,
    output logic                ir_we_o,
    output logic                pc_we_o,
    output logic [1:0]          pc_src_o,
    output logic [2:0]          imm_sel_o,
    output logic                alu_a_sel_o,
    output logic                alu_b_sel_o,
    output logic                rf_we_o,
    output logic [1:0]          wb_sel_o,
    output logic                illegal_o,
    output logic [2:0]          state_o,
    output logic [RETIRE_W-1:0] retired_o
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    localparam logic [6:0] c_opc_op     = 7'b0110011;
    localparam logic [6:0] c_opc_opimm  = 7'b0010011;
    localparam logic [6:0] c_opc_load   = 7'b0000011;
    localparam logic [6:0] c_opc_store  = 7'b0100011;
    localparam logic [6:0] c_opc_branch = 7'b1100011;
    localparam logic [6:0] c_opc_jal    = 7'b1101111;
    localparam logic [6:0] c_opc_jalr   = 7'b1100111;
    localparam logic [6:0] c_opc_lui    = 7'b0110111;
    localparam logic [6:0] c_opc_auipc  = 7'b0010111;

    localparam logic [2:0] c_imm_none = 3'd0;
    localparam logic [2:0] c_imm_i    = 3'd1;
    localparam logic [2:0] c_imm_s    = 3'd2;
    localparam logic [2:0] c_imm_b    = 3'd3;
    localparam logic [2:0] c_imm_u    = 3'd4;
    localparam logic [2:0] c_imm_j    = 3'd5;

    localparam logic [RETIRE_W-1:0] c_retire_one = RETIRE_W'(1);

    state_t              state_q, state_d;
    logic [RETIRE_W-1:0] retired_q;
    logic                illegal_q;

    logic [6:0] w_opc;
    logic       w_is_op, w_is_opimm, w_is_load, w_is_store, w_is_branch;
    logic       w_is_jal, w_is_jalr, w_is_lui, w_is_auipc, w_legal;
    logic [2:0] w_imm_fmt;
    logic       w_alu_a, w_alu_b;
    logic       w_retire;
    logic       w_unused_inst;

    // Only the opcode field steers sequencing; the rest of the word feeds
    // the datapath directly.
    assign w_opc         = inst_i[6:0];
    assign w_unused_inst = ^inst_i[31:7];

    assign w_is_op     = (w_opc == c_opc_op);
    assign w_is_opimm  = (w_opc == c_opc_opimm);
    assign w_is_load   = (w_opc == c_opc_load);
    assign w_is_store  = (w_opc == c_opc_store);
    assign w_is_branch = (w_opc == c_opc_branch);
    assign w_is_jal    = (w_opc == c_opc_jal);
    assign w_is_jalr   = (w_opc == c_opc_jalr);
    assign w_is_lui    = (w_opc == c_opc_lui);
    assign w_is_auipc  = (w_opc == c_opc_auipc);
    assign w_legal     = w_is_op | w_is_opimm | w_is_load | w_is_store |
                         w_is_branch | w_is_jal | w_is_jalr | w_is_lui |
                         w_is_auipc;

    always_comb begin
        w_imm_fmt = c_imm_none;
        if (w_is_opimm || w_is_load || w_is_jalr) begin
            w_imm_fmt = c_imm_i;
        end else if (w_is_store) begin
            w_imm_fmt = c_imm_s;
        end else if (w_is_branch) begin
            w_imm_fmt = c_imm_b;
        end else if (w_is_lui || w_is_auipc) begin
            w_imm_fmt = c_imm_u;
        end else if (w_is_jal) begin
            w_imm_fmt = c_imm_j;
        end
    end

    // ALU operand selection for the instruction's own computation. Held from
    // EXEC through WB so the ALU result stays stable for writeback.
    // Branches compare rs1/rs2, so they keep both selects at zero.
    assign w_alu_a = w_is_auipc;
    assign w_alu_b = w_is_auipc | w_is_opimm | w_is_load | w_is_store |
                     w_is_jalr;

    // ------------------------------------------------------------------
    // Next-state and Moore output decode
    // ------------------------------------------------------------------
    always_comb begin
        state_d        = state_q;
        mem_req_o      = 1'b0;
        mem_we_o       = 1'b0;
        mem_addr_sel_o = 1'b0;
        ir_we_o        = 1'b0;
        pc_we_o        = 1'b0;
        pc_src_o       = 2'd0;
        imm_sel_o      = c_imm_none;
        alu_a_sel_o    = 1'b0;
        alu_b_sel_o    = 1'b0;
        rf_we_o        = 1'b0;
        wb_sel_o       = 2'd0;
        w_retire       = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_req_o = 1'b1;
                if (mem_ready_i) begin
                    ir_we_o = 1'b1;
                    state_d = S_DECODE;
                end
            end

            S_DECODE: begin
                imm_sel_o = w_imm_fmt;
                state_d   = w_legal ? S_EXEC : S_TRAP;
            end

            S_EXEC: begin
                imm_sel_o   = w_imm_fmt;
                alu_a_sel_o = w_alu_a;
                alu_b_sel_o = w_alu_b;
                if (w_is_branch) begin
                    // Branches resolve and retire here; the PC always moves,
                    // either to the target or to PC+4.
                    pc_we_o  = 1'b1;
                    pc_src_o = br_taken_i ? 2'd1 : 2'd0;
                    w_retire = 1'b1;
                    state_d  = S_FETCH;
                end else if (w_is_load || w_is_store) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end

            S_MEM: begin
                // Address select, ALU operands and mem_we are constant for
                // the whole request so the address is stable while waiting.
                imm_sel_o      = w_imm_fmt;
                alu_a_sel_o    = w_alu_a;
                alu_b_sel_o    = 1'b1;
                mem_req_o      = 1'b1;
                mem_addr_sel_o = 1'b1;
                mem_we_o       = w_is_store;
                if (mem_ready_i) begin
                    if (w_is_store) begin
                        pc_we_o  = 1'b1;
                        w_retire = 1'b1;
                        state_d  = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end

            S_WB: begin
                imm_sel_o   = w_imm_fmt;
                alu_a_sel_o = w_alu_a;
                alu_b_sel_o = w_alu_b;
                rf_we_o     = 1'b1;
                pc_we_o     = 1'b1;
                w_retire    = 1'b1;
                state_d     = S_FETCH;
                if (w_is_load) begin
                    wb_sel_o = 2'd1;
                end else if (w_is_jal || w_is_jalr) begin
                    wb_sel_o = 2'd2;
                end else if (w_is_lui) begin
                    wb_sel_o = 2'd3;
                end
                if (w_is_jal) begin
                    pc_src_o = 2'd1;
                end else if (w_is_jalr) begin
                    pc_src_o = 2'd2;
                end
            end

            S_TRAP: begin
                state_d = S_TRAP;
            end

            default: begin
                state_d = S_FETCH;
            end
        endcase

        // Reset wins over everything in the same cycle: any request in
        // flight is dropped and nothing architectural is updated.
        if (rst) begin
            mem_req_o      = 1'b0;
            mem_we_o       = 1'b0;
            mem_addr_sel_o = 1'b0;
            ir_we_o        = 1'b0;
            pc_we_o        = 1'b0;
            pc_src_o       = 2'd0;
            imm_sel_o      = c_imm_none;
            alu_a_sel_o    = 1'b0;
            alu_b_sel_o    = 1'b0;
            rf_we_o        = 1'b0;
            wb_sel_o       = 2'd0;
            w_retire       = 1'b0;
            state_d        = S_FETCH;
        end
    end

    // ------------------------------------------------------------------
    // State, retire counter and sticky trap flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            retired_q <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (w_retire) begin
                retired_q <= retired_q + c_retire_one;
            end
            if (state_d == S_TRAP) begin
                illegal_q <= 1'b1;
            end
        end
    end

    assign illegal_o = illegal_q;
    assign state_o   = state_q;
    assign retired_o = retired_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multicycle_ctrl
//  Purpose  : Self-checking bench for multicycle_ctrl. Instructions are
//             expanded into per-cycle expectations from the instruction-class
//             timing rules; a monitor compares each cycle against the DUT.
//             A second instance with a 4-bit retire counter exercises wrap.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] inst;
    logic        mem_ready;
    logic        br_taken;

    logic        mem_req, mem_we, mem_addr_sel, ir_we, pc_we;
    logic [1:0]  pc_src;
    logic [2:0]  imm_sel;
    logic        alu_a_sel, alu_b_sel, rf_we;
    logic [1:0]  wb_sel;
    logic        illegal;
    logic [2:0]  state;
    logic [31:0] retired;

    logic        d4_mem_req, d4_mem_we, d4_mem_addr_sel, d4_ir_we, d4_pc_we;
    logic [1:0]  d4_pc_src;
    logic [2:0]  d4_imm_sel;
    logic        d4_alu_a_sel, d4_alu_b_sel, d4_rf_we;
    logic [1:0]  d4_wb_sel;
    logic        d4_illegal;
    logic [2:0]  d4_state;
    logic [3:0]  d4_retired;

    always #5 clk = ~clk;

    multicycle_ctrl dut (
        .clk(clk), .rst(rst), .inst_i(inst), .mem_ready_i(mem_ready),
        .br_taken_i(br_taken), .mem_req_o(mem_req), .mem_we_o(mem_we),
        .mem_addr_sel_o(mem_addr_sel), .ir_we_o(ir_we), .pc_we_o(pc_we),
        .pc_src_o(pc_src), .imm_sel_o(imm_sel), .alu_a_sel_o(alu_a_sel),
        .alu_b_sel_o(alu_b_sel), .rf_we_o(rf_we), .wb_sel_o(wb_sel),
        .illegal_o(illegal), .state_o(state), .retired_o(retired)
    );

    multicycle_ctrl #(.RETIRE_W(4)) dut4 (
        .clk(clk), .rst(rst), .inst_i(inst), .mem_ready_i(mem_ready),
        .br_taken_i(br_taken), .mem_req_o(d4_mem_req), .mem_we_o(d4_mem_we),
        .mem_addr_sel_o(d4_mem_addr_sel), .ir_we_o(d4_ir_we),
        .pc_we_o(d4_pc_we), .pc_src_o(d4_pc_src), .imm_sel_o(d4_imm_sel),
        .alu_a_sel_o(d4_alu_a_sel), .alu_b_sel_o(d4_alu_b_sel),
        .rf_we_o(d4_rf_we), .wb_sel_o(d4_wb_sel), .illegal_o(d4_illegal),
        .state_o(d4_state), .retired_o(d4_retired)
    );

    typedef enum {K_OP, K_OPIMM, K_LOAD, K_STORE, K_BR, K_JAL, K_JALR,
                  K_LUI, K_AUIPC, K_ILL} kind_t;

    // One clock cycle: inputs to apply plus the outputs required.
    typedef struct packed {
        logic        rst;
        logic [31:0] inst;
        logic        rdy;
        logic        br;
        logic [2:0]  st;
        logic        req;
        logic        we;
        logic        asel;
        logic        ir;
        logic        pcwe;
        logic [1:0]  pcsrc;
        logic [2:0]  imm;
        logic        alua;
        logic        alub;
        logic        rf;
        logic [1:0]  wbsel;
        logic        ill;
        logic [31:0] ret;
        logic        c_asel;
        logic        c_pcsrc;
        logic        c_imm;
        logic        c_alu;
        logic        c_wb;
    } cyc_t;

    cyc_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] retired_m = 32'd0;
    logic        illegal_m = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    function automatic kind_t kind_of(input logic [31:0] w);
        case (w[6:0])
            7'b0110011: return K_OP;
            7'b0010011: return K_OPIMM;
            7'b0000011: return K_LOAD;
            7'b0100011: return K_STORE;
            7'b1100011: return K_BR;
            7'b1101111: return K_JAL;
            7'b1100111: return K_JALR;
            7'b0110111: return K_LUI;
            7'b0010111: return K_AUIPC;
            default:    return K_ILL;
        endcase
    endfunction

    function automatic logic [2:0] imm_of(input kind_t k);
        case (k)
            K_OPIMM, K_LOAD, K_JALR: return 3'd1;
            K_STORE:                 return 3'd2;
            K_BR:                    return 3'd3;
            K_LUI, K_AUIPC:          return 3'd4;
            K_JAL:                   return 3'd5;
            default:                 return 3'd0;
        endcase
    endfunction

    // Idle cycle: no enables, random don't-care inputs.
    function automatic cyc_t blank(input logic [31:0] w);
        cyc_t c;
        c      = '0;
        c.inst = w;
        c.rdy  = 1'($urandom_range(0, 1));
        c.br   = 1'($urandom_range(0, 1));
        c.ret  = retired_m;
        c.ill  = illegal_m;
        return c;
    endfunction

    function automatic cyc_t make_rst(input cyc_t ci);
        cyc_t c;
        c         = ci;
        c.rst     = 1'b1;
        c.req     = 1'b0; c.we   = 1'b0; c.ir   = 1'b0;
        c.pcwe    = 1'b0; c.rf   = 1'b0;
        c.asel    = 1'b0; c.pcsrc = 2'd0; c.imm = 3'd0;
        c.alua    = 1'b0; c.alub = 1'b0; c.wbsel = 2'd0;
        c.c_asel  = 1'b1; c.c_pcsrc = 1'b1; c.c_imm = 1'b1;
        c.c_alu   = 1'b1; c.c_wb = 1'b1;
        return c;
    endfunction

    task automatic drive(input cyc_t c);
        rst       = c.rst;
        inst      = c.inst;
        mem_ready = c.rdy;
        br_taken  = c.br;
        sb.push_back(c);
        @(posedge clk);
        #1;
    endtask

    // Expand one instruction into its cycle sequence, optionally replacing
    // cycle abort_at with a reset (and dropping the rest).
    task automatic run_instr(input logic [31:0] w, input int fw, input int mw,
                             input logic br, input int abort_at,
                             input int trap_len);
        cyc_t  cq[$];
        cyc_t  c;
        kind_t k;
        bit    aborted;
        k = kind_of(w);

        for (int i = 0; i <= fw; i++) begin
            c        = blank(w);
            c.inst   = $urandom;
            c.rdy    = (i == fw);
            c.st     = 3'd0;
            c.req    = 1'b1;
            c.c_asel = 1'b1;
            c.ir     = (i == fw);
            cq.push_back(c);
        end

        c = blank(w); c.st = 3'd1; c.imm = imm_of(k); c.c_imm = 1'b1;
        cq.push_back(c);

        if (k == K_ILL) begin
            for (int i = 0; i < trap_len; i++) begin
                c = blank(w); c.st = 3'd5; c.ill = 1'b1;
                cq.push_back(c);
            end
            c = blank(w); c.st = 3'd5; c.ill = 1'b1;
            cq.push_back(make_rst(c));
        end else begin
            c = blank(w); c.st = 3'd2; c.imm = imm_of(k); c.c_imm = 1'b1;
            if (k == K_AUIPC) begin
                c.alua = 1'b1; c.alub = 1'b1; c.c_alu = 1'b1;
            end
            if (k == K_LOAD || k == K_STORE) begin
                c.alua = 1'b0; c.alub = 1'b1; c.c_alu = 1'b1;
            end
            if (k == K_BR) begin
                c.br = br; c.pcwe = 1'b1; c.pcsrc = br ? 2'd1 : 2'd0;
                c.c_pcsrc = 1'b1;
            end
            cq.push_back(c);

            if (k == K_LOAD || k == K_STORE) begin
                for (int i = 0; i <= mw; i++) begin
                    c = blank(w); c.st = 3'd3; c.req = 1'b1; c.asel = 1'b1;
                    c.c_asel = 1'b1; c.we = (k == K_STORE);
                    c.imm = imm_of(k); c.c_imm = 1'b1; c.rdy = (i == mw);
                    if (i == mw && k == K_STORE) begin
                        c.pcwe = 1'b1; c.pcsrc = 2'd0; c.c_pcsrc = 1'b1;
                    end
                    cq.push_back(c);
                end
            end

            if (k != K_BR && k != K_STORE) begin
                c = blank(w); c.st = 3'd4; c.imm = imm_of(k); c.c_imm = 1'b1;
                c.rf = 1'b1; c.pcwe = 1'b1; c.c_wb = 1'b1; c.c_pcsrc = 1'b1;
                c.wbsel = (k == K_LOAD) ? 2'd1 :
                          (k == K_JAL || k == K_JALR) ? 2'd2 :
                          (k == K_LUI) ? 2'd3 : 2'd0;
                c.pcsrc = (k == K_JAL) ? 2'd1 : (k == K_JALR) ? 2'd2 : 2'd0;
                cq.push_back(c);
            end
        end

        aborted = 1'b0;
        if (abort_at >= 0 && abort_at < cq.size()) begin
            while (cq.size() > abort_at + 1) void'(cq.pop_back());
            c = cq.pop_back();
            cq.push_back(make_rst(c));
            aborted = 1'b1;
        end

        foreach (cq[i]) drive(cq[i]);

        if (aborted || k == K_ILL) begin
            retired_m = 32'd0;
            illegal_m = 1'b0;
        end else begin
            retired_m = retired_m + 32'd1;
        end
    endtask

    always @(negedge clk) begin
        cyc_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("state",   32'(state),   32'(e.st));
            chk("mem_req", 32'(mem_req), 32'(e.req));
            chk("mem_we",  32'(mem_we),  32'(e.we));
            chk("ir_we",   32'(ir_we),   32'(e.ir));
            chk("pc_we",   32'(pc_we),   32'(e.pcwe));
            chk("rf_we",   32'(rf_we),   32'(e.rf));
            chk("illegal", 32'(illegal), 32'(e.ill));
            chk("retired", retired,      e.ret);
            chk("retired4", 32'(d4_retired), {28'd0, e.ret[3:0]});
            if (e.c_asel)  chk("mem_addr_sel", 32'(mem_addr_sel), 32'(e.asel));
            if (e.c_pcsrc) chk("pc_src",  32'(pc_src),  32'(e.pcsrc));
            if (e.c_imm)   chk("imm_sel", 32'(imm_sel), 32'(e.imm));
            if (e.c_wb)    chk("wb_sel",  32'(wb_sel),  32'(e.wbsel));
            if (e.c_alu) begin
                chk("alu_a_sel", 32'(alu_a_sel), 32'(e.alua));
                chk("alu_b_sel", 32'(alu_b_sel), 32'(e.alub));
            end
        end
    end

    logic [6:0] legal_opc [9] = '{7'b0110011, 7'b0010011, 7'b0000011,
                                  7'b0100011, 7'b1100011, 7'b1101111,
                                  7'b1100111, 7'b0110111, 7'b0010111};

    initial begin
        cyc_t        c;
        logic [31:0] r;
        logic [6:0]  opc;
        int          ab;

        rst = 1'b1; inst = 32'd0; mem_ready = 1'b0; br_taken = 1'b0;
        @(posedge clk);
        #1;
        c = blank(32'd0);
        c.st = 3'd0;
        drive(make_rst(c));

        // Directed sequences
        run_instr(32'h00500093, 0, 0, 1'b0, -1, 0);   // ADDI
        run_instr(32'h0040A103, 0, 2, 1'b0, -1, 0);   // LW, 2 wait cycles
        run_instr(32'hFE000EE3, 0, 0, 1'b1, -1, 0);   // BEQ taken
        run_instr(32'hFE000EE3, 1, 0, 1'b0, -1, 0);   // BEQ not taken
        run_instr(32'h000080E7, 0, 0, 1'b0, -1, 0);   // JALR
        run_instr(32'h0020A223, 0, 0, 1'b0, -1, 0);   // SW
        run_instr(32'h0000007F, 0, 0, 1'b0, -1, 20);  // illegal, trap, reset
        run_instr(32'h0020A223, 0, 3, 1'b0, 4, 0);    // SW reset while waiting

        for (int i = 0; i < 17; i++) run_instr(32'h00500093, 0, 0, 1'b0, -1, 0);
        chk("wrap4_after17", 32'(d4_retired), 32'd1);
        chk("retired_after17", retired, 32'd17);

        // Randomized mix
        for (int n = 0; n < 300; n++) begin
            r = $urandom;
            if ($urandom_range(0, 19) == 0) begin
                do opc = 7'($urandom); while (kind_of({25'd0, opc}) != K_ILL);
            end else begin
                opc = legal_opc[$urandom_range(0, 8)];
            end
            ab = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 7)) : -1;
            run_instr({r[31:7], opc}, int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                      ab, int'($urandom_range(1, 6)));
        end

        repeat (2) @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle sequencer for the single-issue RV32I core. It decodes the latched instruction word, steps the datapath through FETCH/DECODE/EXEC/MEM/WB, and selects the immediate format that the immediate generator must produce. It drives all register, PC, memory and writeback enables, and handshakes with a single shared instruction/data memory port.

## Interface
- `RETIRE_W`, default 32: width of the retired-instruction counter.
- `clk`  in  1: core clock; all state changes on the rising edge.
- `rst`  in  1: reset, synchronous and active-high (one clock; polarity and synchronicity fixed).
- `inst`  in  32: instruction register contents, valid from DECODE onward.
- `mem_ready`  in  1: memory completes the current request this cycle.
- `br_taken`  in  1: branch comparison result from the ALU, sampled in EXEC.
- `mem_req`  out  1: memory request, held until `mem_ready`.
- `mem_we`  out  1: store request (qualifies `mem_req`).
- `mem_addr_sel`  out  1: 0 = PC (fetch), 1 = ALU result (load/store).
- `ir_we`  out  1: latch the fetched word into the instruction register.
- `pc_we`  out  1: update PC.
- `pc_src`  out  2: 0 = PC+4, 1 = PC+imm, 2 = (rs1+imm) with bit0 cleared.
- `imm_sel`  out  3: 0 none, 1 I, 2 S, 3 B, 4 U, 5 J.
- `alu_a_sel`  out  1: 0 = rs1, 1 = PC.
- `alu_b_sel`  out  1: 0 = rs2, 1 = immediate.
- `rf_we`  out  1: register-file write.
- `wb_sel`  out  2: 0 = ALU, 1 = memory data, 2 = PC+4, 3 = immediate (LUI).
- `illegal`  out  1: unsupported opcode trapped; sticky.
- `state`  out  3: current state (debug).
- `retired`  out  `RETIRE_W`: count of completed instructions.

## Operation
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5. Outputs are a Moore decode of `state` and `inst[6:0]`; `ir_we` and the MEM-state enables are additionally gated by `mem_ready`.
- FETCH: `mem_req`=1, `mem_addr_sel`=0. Stay in FETCH until `mem_ready`; in that cycle `ir_we`=1, next state DECODE.
- DECODE: `imm_sel` is set from the opcode: 0010011/0000011/1100111 -> I; 0100011 -> S; 1100011 -> B; 0110111/0010111 -> U; 1101111 -> J; 0110011 -> 0. Any other opcode -> TRAP; otherwise -> EXEC.
- EXEC, with `imm_sel` held: OP/OP-IMM and LUI/AUIPC -> WB. LOAD/STORE compute the address (`alu_b_sel`=1) -> MEM. BRANCH: `pc_we`=1, `pc_src`=`br_taken`?1:0, `retired`++ -> FETCH. JAL/JALR -> WB. AUIPC: `alu_a_sel`=1, `alu_b_sel`=1.
- MEM: `mem_req`=1, `mem_addr_sel`=1, `mem_we`=1 for STORE only; wait on `mem_ready`. On ready, LOAD -> WB. STORE: `pc_we`=1, `pc_src`=0, `retired`++ -> FETCH.
- WB: `rf_we`=1 and `pc_we`=1 for one cycle; `retired`++ -> FETCH. `wb_sel`: LOAD 1, JAL/JALR 2, LUI 3, else 0. `pc_src`: JAL 1, JALR 2, else 0.
- TRAP: all enables 0, `illegal`=1; leave only on `rst`.
- `retired` wraps modulo 2^`RETIRE_W`.

## Timing
- Reset: at the next edge with `rst`=1, state goes to FETCH, `retired`=0 and `illegal`=0. While `rst`=1, every enable output is forced to 0 (`mem_req`, `mem_we`, `ir_we`, `pc_we`, `rf_we`) and `pc_src`, `imm_sel`, `wb_sel`, `alu_*_sel` and `mem_addr_sel` read 0. The first fetch request appears in the first cycle after `rst` falls.
- Reset mid-instruction (any state, including while waiting on `mem_ready`): the request is dropped in that cycle with no PC, register-file or retire update.
- Cycle counts with zero-wait memory (`mem_ready` high in the first request cycle): BRANCH 3; OP/OP-IMM/LUI/AUIPC/JAL/JALR/STORE 4; LOAD 5. Each wait cycle in FETCH or MEM adds 1.
- `mem_req` never deasserts before `mem_ready`, and address and `mem_we` are stable while it is held. `mem_ready` outside FETCH/MEM is ignored.
- Exactly one `pc_we` pulse per retired instruction, in the same cycle as the `retired` increment. `rf_we` is never asserted for BRANCH or STORE.

## Test plan
- ADDI, `inst`=0x00500093, zero-wait memory -> states 0,1,2,4,0. `imm_sel`=1 from DECODE; one `rf_we` pulse in WB with `wb_sel`=0; `pc_src`=0; `retired` goes 0->1.
- LW, `inst`=0x0040A103, `mem_ready` low for 2 cycles in MEM -> states 0,1,2,3,3,3,4 with `mem_req` held throughout; WB `wb_sel`=1; 7 cycles total.
- BEQ, `inst`=0xFE000EE3, with `br_taken`=1 and then with `br_taken`=0 -> `imm_sel`=3 and EXEC `pc_we`=1 with `pc_src`=1 and 0 respectively; `rf_we` never asserted.
- JALR, `inst`=0x000080E7 -> WB shows `rf_we`=1, `wb_sel`=2, `pc_src`=2, `imm_sel`=1. Then SW 0x0020A223 -> MEM shows `mem_we`=1 and `imm_sel`=2.
- Illegal `inst`=0x0000007F -> TRAP after DECODE with `illegal`=1 and all enables 0 for 20 cycles; `rst` pulse -> FETCH with `illegal`=0.
- `rst` asserted in MEM of a store while `mem_ready`=0 -> next cycle state=0 with no `pc_we` and `retired` unchanged. Separately, preload `retired` near wrap using `RETIRE_W`=4 and retire 17 instructions -> `retired`=1.
